instr_sequencer: RTL and testbench

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/simple_proc_pkg.sv | 28 ++
 rtl/simple_processor_intf.sv | 12 +
 rtl/prog_mem.sv | 28 ++
 rtl/instr_sequencer.sv | 126 ++++++++++++
 tb/tb_instr_sequencer.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/simple_proc_pkg.sv
// Shared definitions for the simple processor and its instruction sequencer:
// opcode encodings, sequencer state encodings and default sizing.
package simple_proc_pkg;

  typedef enum logic [2:0] {
    OP_MV  = 3'b000,
    OP_MVI = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011
  } opcode_e;

  typedef enum logic [2:0] {
    SEQ_IDLE  = 3'd0,
    SEQ_ISSUE = 3'd1,
    SEQ_WAIT  = 3'd2,
    SEQ_FIN   = 3'd3,
    SEQ_ERR   = 3'd4
  } seq_state_e;

  localparam int SEQ_DEFAULT_DEPTH   = 16;
  localparam int SEQ_DEFAULT_TIMEOUT = 15;

  // mvi carries its immediate in the following program word
  function automatic logic is_mvi(input logic [2:0] op);
    return op == OP_MVI;
  endfunction

endpackage

// File: rtl/simple_processor_intf.sv
// Instruction hand-off between a sequencer (master) and the processor (slave).
interface simple_processor_intf;

  logic       Run;
  logic [8:0] DIN;
  logic       Done;
  logic [8:0] Bus;

  modport master (output Run, output DIN, input Done, input Bus);
  modport slave  (input Run, input DIN, output Done, output Bus);

endinterface

// File: rtl/prog_mem.sv
// Program store: DEPTH x 9 register file, synchronous write, two async read ports.
// Contents are deliberately not reset so a program survives a sequencer reset.
module prog_mem #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [8:0]    wdata,
  input  logic [AW-1:0] raddr_a,
  output logic [8:0]    rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [8:0]    rdata_b
);

  logic [8:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/instr_sequencer.sv
// Walks a loaded program, issuing one instruction (plus mvi immediate) per
// Run strobe and waiting for the processor's Done, with a bounded wait.
module instr_sequencer
  import simple_proc_pkg::*;
#(
  parameter  int DEPTH   = SEQ_DEFAULT_DEPTH,
  parameter  int TIMEOUT = SEQ_DEFAULT_TIMEOUT,
  localparam int AW      = $clog2(DEPTH),
  localparam int PW      = AW + 1
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [8:0]    load_data,
  input  logic [PW-1:0] prog_len,
  input  logic          start,
  output logic          busy,
  output logic          finished,
  output logic [8:0]    last_bus,
  output logic          timeout_err,
  simple_processor_intf.master proc
);

  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] ST_IDLE  = SEQ_IDLE;
  localparam logic [2:0] ST_ISSUE = SEQ_ISSUE;
  localparam logic [2:0] ST_WAIT  = SEQ_WAIT;
  localparam logic [2:0] ST_FIN   = SEQ_FIN;
  localparam logic [2:0] ST_ERR   = SEQ_ERR;

  logic [2:0]    state_reg;
  logic [PW-1:0] pc_reg;
  logic [PW-1:0] len_reg;
  logic [2:0]    op_reg;
  logic [TW-1:0] timer_reg;
  logic [8:0]    last_bus_reg;
  logic          timeout_err_reg;

  logic [8:0]    word_cur;
  logic [8:0]    word_nxt;
  logic [PW-1:0] pc_plus1;
  logic [PW-1:0] pc_step;
  logic          mem_we;

  assign pc_plus1 = pc_reg + PW'(1);
  assign pc_step  = pc_reg + (is_mvi(op_reg) ? PW'(2) : PW'(1));
  assign mem_we   = load_en && (state_reg == ST_IDLE);

  prog_mem #(.DEPTH(DEPTH)) u_prog_mem (
    .clk     (Clock),
    .we      (mem_we),
    .waddr   (load_addr),
    .wdata   (load_data),
    .raddr_a (pc_reg[AW-1:0]),
    .rdata_a (word_cur),
    .raddr_b (pc_plus1[AW-1:0]),
    .rdata_b (word_nxt)
  );

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_reg       <= ST_IDLE;
      pc_reg          <= '0;
      len_reg         <= '0;
      op_reg          <= '0;
      timer_reg       <= '0;
      last_bus_reg    <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            len_reg         <= prog_len;
            pc_reg          <= '0;
            timeout_err_reg <= 1'b0;
            state_reg       <= (prog_len == '0) ? ST_FIN : ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          op_reg    <= word_cur[8:6];
          timer_reg <= '0;
          state_reg <= ST_WAIT;
        end
        ST_WAIT: begin
          if (proc.Done) begin
            last_bus_reg <= proc.Bus;
            pc_reg       <= pc_step;
            state_reg    <= (pc_step >= len_reg) ? ST_FIN : ST_ISSUE;
          end else if (timer_reg == TW'(TIMEOUT - 1)) begin
            // this cycle is the TIMEOUT-th without Done
            timeout_err_reg <= 1'b1;
            state_reg       <= ST_ERR;
          end else begin
            timer_reg <= timer_reg + TW'(1);
          end
        end
        ST_FIN:  state_reg <= ST_IDLE;
        ST_ERR:  state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // an mvi whose immediate lies beyond the program end gets a zero immediate
  always_comb begin
    proc.DIN = 9'h000;
    case (state_reg)
      ST_ISSUE: proc.DIN = word_cur;
      ST_WAIT: begin
        if (is_mvi(op_reg) && (pc_plus1 < len_reg)) begin
          proc.DIN = word_nxt;
        end
      end
      default: proc.DIN = 9'h000;
    endcase
  end

  assign proc.Run    = (state_reg == ST_ISSUE);
  assign busy        = (state_reg == ST_ISSUE) || (state_reg == ST_WAIT);
  assign finished    = (state_reg == ST_FIN);
  assign last_bus    = last_bus_reg;
  assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomised bench for instr_sequencer: a program-walk model predicts every
// issued word, immediate, completion and timeout, and a processor stub answers Run.
module tb_instr_sequencer;
  import simple_proc_pkg::*;

  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 15;
  localparam int AW      = 4;

  logic          Clock     = 1'b0;
  logic          Resetn    = 1'b1;
  logic          load_en   = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [8:0]    load_data = '0;
  logic [AW:0]   prog_len  = '0;
  logic          start     = 1'b0;
  logic          busy;
  logic          finished;
  logic          timeout_err;
  logic [8:0]    last_bus;

  simple_processor_intf proc ();

  instr_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .Clock       (Clock),
    .Resetn      (Resetn),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .prog_len    (prog_len),
    .start       (start),
    .busy        (busy),
    .finished    (finished),
    .last_bus    (last_bus),
    .timeout_err (timeout_err),
    .proc        (proc)
  );

  always #5 Clock = ~Clock;

  logic [8:0] model_mem [DEPTH];
  logic [8:0] model_last = '0;
  logic [8:0] exp_word [$];
  logic [8:0] exp_imm  [$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag, input logic run, input logic [8:0] din,
                               input logic bsy, input logic fin, input logic err);
    check({tag, ".Run"},         32'(proc.Run),    32'(run));
    check({tag, ".DIN"},         32'(proc.DIN),    32'(din));
    check({tag, ".busy"},        32'(busy),        32'(bsy));
    check({tag, ".finished"},    32'(finished),    32'(fin));
    check({tag, ".timeout_err"}, 32'(timeout_err), 32'(err));
    check({tag, ".last_bus"},    32'(last_bus),    32'(model_last));
  endtask

  function automatic logic [8:0] rand_word();
    logic [2:0] op;
    op = ($urandom_range(0, 2) == 0) ? 3'(OP_MVI) : 3'($urandom_range(0, 7));
    return {op, 6'($urandom)};
  endfunction

  // Walk the program as the processor sees it: word, optional immediate, advance.
  function automatic void build_expected(input int len);
    int pc;
    logic [8:0] w;
    exp_word.delete();
    exp_imm.delete();
    pc = 0;
    while (pc < len) begin
      w = model_mem[pc];
      exp_word.push_back(w);
      if (w[8:6] == OP_MVI) begin
        exp_imm.push_back((pc + 1 < len) ? model_mem[pc + 1] : 9'h000);
        pc += 2;
      end else begin
        exp_imm.push_back(9'h000);
        pc += 1;
      end
    end
  endfunction

  task automatic load_word(input int a, input logic [8:0] d);
    load_en   = 1'b1;
    load_addr = a[AW-1:0];
    load_data = d;
    model_mem[a] = d;
    @(negedge Clock);
    load_en = 1'b0;
  endtask

  task automatic do_reset();
    Resetn = 1'b0;
    #1;
    model_last = '0;
    check_outputs("reset", 1'b0, 9'h000, 1'b0, 1'b0, 1'b0);
    @(negedge Clock);
    Resetn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge Clock);
      check_outputs("post_reset", 1'b0, 9'h000, 1'b0, 1'b0, 1'b0);
    end
  endtask

  // timeout_at: instruction whose Done is withheld; abort_at: instruction whose WAIT is reset
  task automatic run_prog(input int len, input int min_dly, input int max_dly, input bit poke,
                          input bit sim_load, input int timeout_at, input int abort_at);
    logic [8:0] pend;
    int d;
    pend = '0;
    start    = 1'b1;
    prog_len = len[AW:0];
    if (sim_load) begin
      load_en   = 1'b1;
      load_addr = '0;
      load_data = rand_word();
      model_mem[0] = load_data;
    end
    build_expected(len);
    @(negedge Clock);
    start   = 1'b0;
    load_en = 1'b0;
    if (len == 0) begin
      check_outputs("empty", 1'b0, 9'h000, 1'b0, 1'b1, 1'b0);
      proc.Done = 1'b1;
      proc.Bus  = 9'($urandom);
      @(negedge Clock);
      proc.Done = 1'b0;
      check_outputs("empty_after", 1'b0, 9'h000, 1'b0, 1'b0, 1'b0);
      $display("run len=0: finished with no issue");
      return;
    end
    for (int i = 0; i < exp_word.size(); i++) begin
      check_outputs("issue", 1'b1, exp_word[i], 1'b1, 1'b0, 1'b0);
      if ($urandom_range(0, 3) == 0) begin
        proc.Done = 1'b1;
        proc.Bus  = 9'($urandom);
      end
      d = (i == timeout_at) ? 0 : int'($urandom_range(min_dly, max_dly));
      for (int k = 1; k <= ((d == 0) ? TIMEOUT : d); k++) begin
        @(negedge Clock);
        proc.Done = 1'b0;
        start     = 1'b0;
        load_en   = 1'b0;
        check_outputs("wait", 1'b0, exp_imm[i], 1'b1, 1'b0, 1'b0);
        if (i == abort_at) begin
          do_reset();
          $display("run len=%0d: reset during wait of instr %0d", len, i);
          return;
        end
        if (poke) begin
          load_en   = 1'($urandom);
          load_addr = AW'($urandom);
          load_data = 9'($urandom);
          start     = 1'($urandom);
          prog_len  = (AW + 1)'($urandom);
        end
        if (k == d) begin
          proc.Done = 1'b1;
          proc.Bus  = 9'($urandom);
          pend      = proc.Bus;
        end
      end
      @(negedge Clock);
      proc.Done = 1'b0;
      start     = 1'b0;
      load_en   = 1'b0;
      if (d == 0) begin
        check_outputs("err", 1'b0, 9'h000, 1'b0, 1'b0, 1'b1);
        @(negedge Clock);
        check_outputs("err_idle", 1'b0, 9'h000, 1'b0, 1'b0, 1'b1);
        $display("run len=%0d: timeout at instr %0d", len, i);
        return;
      end
      model_last = pend;
    end
    check_outputs("fin", 1'b0, 9'h000, 1'b0, 1'b1, 1'b0);
    proc.Done = 1'b1;
    proc.Bus  = 9'($urandom);
    @(negedge Clock);
    proc.Done = 1'b0;
    check_outputs("fin_after", 1'b0, 9'h000, 1'b0, 1'b0, 1'b0);
    $display("run len=%0d: %0d instrs, last_bus=%03h", len, exp_word.size(), model_last);
  endtask

  task automatic load_directed();
    load_word(0, 9'h040);  // mvi R0
    load_word(1, 9'h005);  // immediate
    load_word(2, 9'h008);  // mv R1,R0
  endtask

  initial begin
    int len;
    int tmo;
    proc.Done = 1'b0;
    proc.Bus  = '0;
    #2;
    do_reset();
    for (int a = 0; a < DEPTH; a++) load_word(a, rand_word());

    load_directed();
    run_prog(3, 3, 3, 1'b0, 1'b0, -1, -1);
    run_prog(0, 1, 1, 1'b0, 1'b0, -1, -1);
    run_prog(4, 1, 4, 1'b0, 1'b0, 0, -1);
    run_prog(3, TIMEOUT, TIMEOUT, 1'b0, 1'b0, -1, -1);

    load_word(0, 9'h04F);
    load_word(1, 9'h1AB);
    run_prog(1, 1, 6, 1'b0, 1'b0, -1, -1);

    load_directed();
    run_prog(3, 2, 2, 1'b0, 1'b0, -1, 1);
    run_prog(3, 1, 4, 1'b0, 1'b0, -1, -1);

    run_prog(DEPTH, 1, 4, 1'b1, 1'b0, -1, -1);
    run_prog(DEPTH, 1, 4, 1'b0, 1'b0, -1, -1);
    run_prog(5, 1, 3, 1'b0, 1'b1, -1, -1);

    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 1) == 1) load_word(int'($urandom_range(0, DEPTH - 1)), rand_word());
      len = int'($urandom_range(0, DEPTH));
      tmo = ($urandom_range(0, 5) == 0) ? 0 : -1;
      run_prog(len, 1, TIMEOUT, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), tmo, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
